// File: rtl/pll_reset_sequencer_if.sv
// Sequencer-side bundle: PLL control/status plus downstream domain resets.
// lock_loss_cnt exists only when PLL_SEQ_STATUS_EN is defined.
interface pll_reset_sequencer_if #(
  parameter int NUM_DOMAINS = 2
);
  logic                   pll_locked;
  logic                   restart;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] dom_rst_n;
  logic                   ready;
  logic                   fault;
  logic [1:0]             retry_cnt;
`ifdef PLL_SEQ_STATUS_EN
  logic [7:0]             lock_loss_cnt;

  modport master (
    input  pll_locked, restart,
    output pll_rst, dom_rst_n, ready, fault, retry_cnt, lock_loss_cnt
  );
  modport slave (
    output pll_locked, restart,
    input  pll_rst, dom_rst_n, ready, fault, retry_cnt, lock_loss_cnt
  );
`else
  modport master (
    input  pll_locked, restart,
    output pll_rst, dom_rst_n, ready, fault, retry_cnt
  );
  modport slave (
    output pll_locked, restart,
    input  pll_rst, dom_rst_n, ready, fault, retry_cnt
  );
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer with retry, lock qualification and staggered domain release.
// Optional PLL_SEQ_STATUS_EN adds a saturating lock-loss counter.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int STAGGER       = 8,
  parameter int MAX_RETRIES   = 3,
  parameter int NUM_DOMAINS   = 2
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.master bus
);
  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                                max2(STABLE_CYCLES, NUM_DOMAINS * STAGGER));
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW:0]   REL_END     = (CW+1)'(NUM_DOMAINS * STAGGER);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {HOLD, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW:0]            cnt_inc;
  logic [1:0]             retry_q, retry_d;
  logic                   fault_q, fault_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   pll_rst_q, ready_q;
  logic [1:0]             sync_q;
  logic                   locked_s;
  logic                   lost;

  assign locked_s = sync_q[1];
  assign cnt_inc  = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fault_d = fault_q;
    dom_d   = dom_q;
    lost    = 1'b0;
    if (bus.restart) begin
      state_d = HOLD;
      cnt_d   = '0;
      retry_d = '0;
      fault_d = 1'b0;
      dom_d   = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else cnt_d = cnt_inc[CW-1:0];
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = FAULT;
              fault_d = 1'b1;
            end else begin
              state_d = HOLD;
              retry_d = retry_q + 2'd1;
            end
          end else cnt_d = cnt_inc[CW-1:0];
        end
        STABLE: begin
          // A glitch only restarts qualification; it is not a failed attempt.
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            lost    = 1'b1;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end else cnt_d = cnt_inc[CW-1:0];
        end
        RELEASE: begin
          if (!locked_s) begin
            state_d = HOLD;
            cnt_d   = '0;
            dom_d   = '0;
            lost    = 1'b1;
          end else begin
            cnt_d = cnt_inc[CW-1:0];
            for (int i = 0; i < NUM_DOMAINS; i++)
              if (cnt_inc == (CW+1)'((i + 1) * STAGGER)) dom_d[i] = 1'b1;
            if (cnt_inc == REL_END) begin
              state_d = RUN;
              cnt_d   = '0;
              retry_d = '0;
            end
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d = HOLD;
            cnt_d   = '0;
            dom_d   = '0;
            lost    = 1'b1;
          end
        end
        FAULT: ;
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          dom_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      retry_q   <= '0;
      fault_q   <= 1'b0;
      dom_q     <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      fault_q   <= fault_d;
      dom_q     <= dom_d;
      pll_rst_q <= (state_d == HOLD) || (state_d == FAULT);
      ready_q   <= (state_d == RUN);
      sync_q    <= {sync_q[0], bus.pll_locked};
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.dom_rst_n = dom_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;

`ifdef PLL_SEQ_STATUS_EN
  logic [7:0] llc_q;
  always_ff @(posedge refclk) begin
    if (!rst_n)                     llc_q <= '0;
    else if (lost && llc_q != 8'hFF) llc_q <= llc_q + 8'd1;
  end
  assign bus.lock_loss_cnt = llc_q;
`endif
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed + randomized bench for pll_reset_sequencer against a phase/elapsed-time model.
module tb_pll_reset_sequencer;
  localparam int RST_CYCLES = 16, LOCK_TIMEOUT = 4096, STABLE_CYCLES = 256;
  localparam int STAGGER = 8, MAX_RETRIES = 3, ND = 2;
  localparam int P_HOLD = 0, P_WAIT = 1, P_STAB = 2, P_REL = 3, P_RUN = 4, P_FAULT = 5;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 refclk = ~refclk;

  pll_reset_sequencer_if #(.NUM_DOMAINS(ND)) bus ();
  pll_reset_sequencer_if #(.NUM_DOMAINS(4))  bus2 ();

  pll_reset_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES),
    .STAGGER(STAGGER), .MAX_RETRIES(MAX_RETRIES), .NUM_DOMAINS(ND)
  ) dut (.refclk(refclk), .rst_n(rst_n), .bus(bus));

  pll_reset_sequencer #(
    .RST_CYCLES(2), .LOCK_TIMEOUT(64), .STABLE_CYCLES(4),
    .STAGGER(1), .MAX_RETRIES(3), .NUM_DOMAINS(4)
  ) dut2 (.refclk(refclk), .rst_n(rst_n), .bus(bus2));

  int n_cmp = 0, n_bad = 0;

  // Reference model: phase + cycles elapsed in phase; outputs derived from those.
  int ph = P_HOLD, t = 0, m_retry = 0, m_llc = 0;
  bit m_fault = 0;
  bit [1:0] m_sync = 0;

  always @(posedge refclk) begin
    bit ls;
    ls = m_sync[1];
    if (!rst_n) begin
      ph = P_HOLD; t = 0; m_retry = 0; m_fault = 0; m_llc = 0;
    end else if (bus.restart) begin
      ph = P_HOLD; t = 0; m_retry = 0; m_fault = 0;
    end else begin
      case (ph)
        P_HOLD: begin t++; if (t == RST_CYCLES) begin ph = P_WAIT; t = 0; end end
        P_WAIT:
          if (ls) begin ph = P_STAB; t = 0; end
          else begin
            t++;
            if (t == LOCK_TIMEOUT) begin
              t = 0;
              if (m_retry == MAX_RETRIES) begin ph = P_FAULT; m_fault = 1; end
              else begin ph = P_HOLD; m_retry++; end
            end
          end
        P_STAB:
          if (!ls) begin ph = P_WAIT; t = 0; m_llc = (m_llc < 255) ? m_llc + 1 : 255; end
          else begin t++; if (t == STABLE_CYCLES) begin ph = P_REL; t = 0; end end
        P_REL:
          if (!ls) begin ph = P_HOLD; t = 0; m_llc = (m_llc < 255) ? m_llc + 1 : 255; end
          else begin t++; if (t == ND * STAGGER) begin ph = P_RUN; t = 0; m_retry = 0; end end
        P_RUN:
          if (!ls) begin ph = P_HOLD; t = 0; m_llc = (m_llc < 255) ? m_llc + 1 : 255; end
        default: ;
      endcase
    end
    m_sync = rst_n ? {m_sync[0], bus.pll_locked} : 2'b00;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ND-1:0] exp_dom();
    logic [ND-1:0] d;
    for (int i = 0; i < ND; i++)
      d[i] = (ph == P_RUN) || (ph == P_REL && t >= (i + 1) * STAGGER);
    return d;
  endfunction

  // Advance one cycle at a time, comparing every output on the falling edge.
  task automatic cyc(int n = 1);
    repeat (n) begin
      @(negedge refclk);
      chk("pll_rst", bus.pll_rst, (ph == P_HOLD || ph == P_FAULT));
      chk("dom_rst_n", bus.dom_rst_n, exp_dom());
      chk("ready", bus.ready, (ph == P_RUN));
      chk("fault", bus.fault, m_fault);
      chk("retry_cnt", bus.retry_cnt, m_retry);
`ifdef PLL_SEQ_STATUS_EN
      chk("lock_loss_cnt", bus.lock_loss_cnt, m_llc);
`endif
    end
  endtask

  task automatic wait_ready(string tag, int budget);
    int k = 0;
    while (!bus.ready && k < budget) begin cyc(); k++; end
    chk(tag, bus.ready, 1'b1);
  endtask

  initial begin
    int t0, t1, k;
    bus.pll_locked = 0; bus.restart = 0;
    bus2.pll_locked = 1; bus2.restart = 0;

    // Reset values
    cyc(3);
    chk("rst_pll_rst", bus.pll_rst, 1'b1);
    chk("rst_dom", bus.dom_rst_n, 2'b00);
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_fault", bus.fault, 1'b0);
    chk("rst_retry", bus.retry_cnt, 2'd0);
    rst_n = 1;

    // Nominal bring-up: lock 100 cycles after pll_rst falls
    k = 0;
    while (bus.pll_rst && k < 100) begin cyc(); k++; end
    chk("hold_len", k, RST_CYCLES);
    cyc(100);
    bus.pll_locked = 1;
    t0 = -1; t1 = -1; k = 0;
    while (!bus.ready && k < 400) begin
      cyc(); k++;
      if (t0 < 0 && bus.dom_rst_n[0]) t0 = k;
      if (t1 < 0 && bus.dom_rst_n[1]) t1 = k;
    end
    chk("boot_ready", bus.ready, 1'b1);
    chk("stagger", t1 - t0, STAGGER);
    cyc(20);

    // Lock drop in RUN: all domains reset together three edges later
    bus.pll_locked = 0;
    cyc(2);
    chk("drop_still_ready", bus.ready, 1'b1);
    cyc();
    chk("drop_dom", bus.dom_rst_n, 2'b00);
    chk("drop_pll_rst", bus.pll_rst, 1'b1);
    cyc($urandom_range(40, 300));
    bus.pll_locked = 1;
    wait_ready("relock_ready", 1000);
`ifdef PLL_SEQ_STATUS_EN
    chk("llc_after_drop", bus.lock_loss_cnt, 8'd1);
`endif

    // Glitch during qualification
    bus.restart = 1; cyc(); bus.restart = 0;
    k = 0;
    while (!(ph == P_STAB && t == 100) && k < 200) begin cyc(); k++; end
    chk("reach_stable", (ph == P_STAB), 1'b1);
    bus.pll_locked = 0; cyc(3); bus.pll_locked = 1;
    k = 0;
    while (bus.dom_rst_n == 2'b00 && k < 400) begin cyc(); k++; end
    chk("glitch_release_delay", (k > STABLE_CYCLES), 1'b1);
    chk("glitch_retry", bus.retry_cnt, 2'd0);
    wait_ready("glitch_ready", 100);

    // Restart mid-release, then restart coinciding with reset
    bus.pll_locked = 0; cyc(5); bus.pll_locked = 1;
    k = 0;
    while (bus.dom_rst_n != 2'b01 && k < 600) begin cyc(); k++; end
    chk("mid_release", bus.dom_rst_n, 2'b01);
    bus.restart = 1; cyc(); bus.restart = 0;
    chk("restart_dom", bus.dom_rst_n, 2'b00);
    chk("restart_pll_rst", bus.pll_rst, 1'b1);
    cyc(30);
    rst_n = 0; bus.restart = 1; cyc();
    bus.restart = 0;
    chk("rst_win_pll_rst", bus.pll_rst, 1'b1);
    chk("rst_win_retry", bus.retry_cnt, 2'd0);
`ifdef PLL_SEQ_STATUS_EN
    chk("rst_win_llc", bus.lock_loss_cnt, 8'd0);
`endif
    rst_n = 1;

    // Never locks: retries exhaust into FAULT
    bus.pll_locked = 0;
    k = 0;
    while (!bus.fault && k < (MAX_RETRIES + 1) * (RST_CYCLES + LOCK_TIMEOUT) + 50) begin
      cyc(); k++;
    end
    chk("fault_set", bus.fault, 1'b1);
    chk("fault_retry", bus.retry_cnt, 2'd3);
    cyc(50);
    chk("fault_pll_rst", bus.pll_rst, 1'b1);
    bus.restart = 1; cyc(); bus.restart = 0;
    chk("fault_clear", bus.fault, 1'b0);
    chk("fault_retry_clear", bus.retry_cnt, 2'd0);

    // Random lock activity with occasional restarts
    for (int it = 0; it < 40; it++) begin
      bus.pll_locked = ($urandom_range(0, 3) != 0);
      bus.restart = ($urandom_range(0, 9) == 0);
      cyc(); bus.restart = 0;
      cyc($urandom_range(1, 500));
    end

    // Four domains, unit stagger: consecutive in-order releases
    bus2.restart = 1; cyc(); bus2.restart = 0;
    k = 0;
    while (bus2.dom_rst_n == 4'b0000 && k < 50) begin cyc(); k++; end
    chk("d4_step0", bus2.dom_rst_n, 4'b0001);
    cyc(); chk("d4_step1", bus2.dom_rst_n, 4'b0011);
    cyc(); chk("d4_step2", bus2.dom_rst_n, 4'b0111);
    chk("d4_not_ready", bus2.ready, 1'b0);
    cyc(); chk("d4_step3", bus2.dom_rst_n, 4'b1111);
    chk("d4_ready", bus2.ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
